fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives an instruction-memory read port and hands
// fetched words with their next-PC to the decode stage, honouring freeze and branch redirects.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] PC,
  output logic        valid
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc;
  logic [31:0] r_mem_addr;
  logic        r_mem_req;
  logic [31:0] r_instr;
  logic [31:0] r_out_pc;
  logic        r_valid;

  logic [31:0] w_pc_inc;
  logic [31:0] w_br_target;

  assign w_pc_inc    = r_pc + 32'd4;
  assign w_br_target = branch_address & 32'hFFFF_FFFC;

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instruction = r_instr;
  assign PC          = r_out_pc;
  assign valid       = r_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_buf_instr <= 32'h0;
      r_buf_pc    <= 32'h0;
      r_mem_addr  <= RESET_PC;
      r_mem_req   <= 1'b0;
      r_instr     <= 32'h0;
      r_out_pc    <= 32'h0;
      r_valid     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state   <= FETCH;
          r_mem_req <= 1'b1;
          if (branch_taken) begin
            r_pc       <= w_br_target;
            r_mem_addr <= w_br_target;
          end else begin
            r_mem_addr <= r_pc;
          end
        end

        FETCH: begin
          if (branch_taken) begin
            r_pc    <= w_br_target;
            r_valid <= 1'b0;
            // An outstanding read cannot be cancelled: keep presenting it and drop its data later.
            if (mem_ready) r_mem_addr <= w_br_target;
            else           r_state    <= DISCARD;
          end else if (mem_ready) begin
            r_pc       <= w_pc_inc;
            r_mem_addr <= w_pc_inc;
            if (freeze) begin
              r_buf_instr <= mem_rdata;
              r_buf_pc    <= w_pc_inc;
              r_mem_req   <= 1'b0;
              r_state     <= HOLD;
            end else begin
              r_instr  <= mem_rdata;
              r_out_pc <= w_pc_inc;
              r_valid  <= 1'b1;
            end
          end else if (!freeze) begin
            r_valid <= 1'b0;
          end
        end

        HOLD: begin
          if (branch_taken) begin
            r_pc        <= w_br_target;
            r_mem_addr  <= w_br_target;
            r_valid     <= 1'b0;
            r_buf_instr <= 32'h0;
            r_buf_pc    <= 32'h0;
            r_mem_req   <= 1'b1;
            r_state     <= FETCH;
          end else if (!freeze) begin
            r_instr   <= r_buf_instr;
            r_out_pc  <= r_buf_pc;
            r_valid   <= 1'b1;
            r_mem_req <= 1'b1;
            r_state   <= FETCH;
          end
        end

        DISCARD: begin
          if (branch_taken) begin
            r_pc    <= w_br_target;
            r_valid <= 1'b0;
          end else if (!freeze) begin
            r_valid <= 1'b0;
          end
          // Stale read completes here; its data is dropped and fetch restarts at the redirect target.
          if (mem_ready) begin
            r_state    <= FETCH;
            r_mem_addr <= branch_taken ? w_br_target : r_pc;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
